// File: rtl/exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exec_ctrl
// Summary  : Program-line sequencer. It steps pc through the program, strobes
//            exec_en for executable lines and runs a request/ack/wait handshake
//            with the sleep stage for SLP lines. Defining the macro
//            EXEC_CTRL_ACK_TIMEOUT_EN adds a 4-clk ack timeout with a sticky err.
// Revision : 1.0  initial release
// ============================================================================
module exec_ctrl #(
   parameter int unsigned PROG_LEN = 9,
   parameter logic [3:0]  SLP_OP   = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        posedge_big_clk,
   input  logic [15:0] instr,
   input  logic        sleep_flag,
   output logic [3:0]  pc,
   output logic [10:0] sleep_val,
   output logic        sleep_req,
   output logic        exec_en,
   output logic        err
);

   localparam logic [3:0] LAST_PC = 4'(PROG_LEN - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      SLP_ACK  = 2'd2,
      SLP_WAIT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  pc_q, pc_d;
   logic [10:0] sleep_val_q, sleep_val_d;
   logic        sleep_req_q, sleep_req_d;
   logic        exec_en_q, exec_en_d;
   logic [3:0]  opcode;
   logic [10:0] imm;
   logic        unused_instr_bit;
   logic        ack_timeout;

   assign opcode           = instr[15:12];
   assign imm              = instr[10:0];
   assign unused_instr_bit = instr[11];

`ifdef EXEC_CTRL_ACK_TIMEOUT_EN
   localparam logic [1:0] ACK_LAST = 2'd3;

   logic [1:0] ack_cnt_q, ack_cnt_d;
   logic       err_q, err_d;

   // Counter is zero on SLP_ACK entry; the 4th silent clk gives up.
   assign ack_timeout = (state_q == SLP_ACK) && !sleep_flag && (ack_cnt_q == ACK_LAST);

   always_comb begin
      ack_cnt_d = '0;
      err_d     = err_q;
      if ((state_q == SLP_ACK) && !sleep_flag) begin
         ack_cnt_d = ack_cnt_q + 2'd1;
      end
      if (ack_timeout) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         ack_cnt_q <= ack_cnt_d;
         err_q     <= err_d;
      end
   end

   assign err = err_q;
`else
   assign ack_timeout = 1'b0;
   assign err         = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      sleep_val_d = sleep_val_q;
      sleep_req_d = 1'b0;
      exec_en_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (posedge_big_clk) begin
               state_d = RUN;
            end
         end
         RUN: begin
            pc_d = (pc_q == LAST_PC) ? 4'd0 : pc_q + 4'd1;
            if (opcode == SLP_OP) begin
               // A zero-length sleep is treated as an empty line.
               if (imm != 11'd0) begin
                  sleep_val_d = imm;
                  sleep_req_d = 1'b1;
                  state_d     = SLP_ACK;
               end
            end else if (opcode != 4'h0) begin
               exec_en_d = 1'b1;
            end
         end
         SLP_ACK: begin
            if (sleep_flag) begin
               state_d = SLP_WAIT;
            end else if (ack_timeout) begin
               state_d = RUN;
            end
         end
         SLP_WAIT: begin
            if (!sleep_flag) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         sleep_val_q <= '0;
         sleep_req_q <= 1'b0;
         exec_en_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         sleep_val_q <= sleep_val_d;
         sleep_req_q <= sleep_req_d;
         exec_en_q   <= exec_en_d;
      end
   end

   assign pc        = pc_q;
   assign sleep_val = sleep_val_q;
   assign sleep_req = sleep_req_q;
   assign exec_en   = exec_en_q;

endmodule
`default_nettype wire

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 The block SHALL have parameter PROG_LEN, default 9, meaning number of program lines, with legal range 2..16.
REQ-002 The block SHALL have parameter SLP_OP, default 4'hF, meaning the opcode value that decodes as SLP.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, all logic rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port posedge_big_clk, input, 1 bit: one-clk pulse marking a time-unit boundary.
REQ-006 The block SHALL have port instr, input, 16 bits: program line at pc, with [15:12] opcode and [10:0] immediate.
REQ-007 The block SHALL have port sleep_flag, input, 1 bit: busy indication returned by the downstream sleep stage.
REQ-008 The block SHALL have port pc, output, 4 bits: current program line index.
REQ-009 The block SHALL have port sleep_val, output, 11 bits: sleep count handed to the sleep stage.
REQ-010 The block SHALL have port sleep_req, output, 1 bit: one-clk request that drives the sleep stage's input_flag.
REQ-011 The block SHALL have port exec_en, output, 1 bit: one-clk strobe to execute the non-SLP line at pc.
REQ-012 The block SHALL have port err, output, 1 bit: sticky sleep-handshake timeout flag.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, RUN, SLP_ACK and SLP_WAIT.
REQ-014 In IDLE, the block SHALL hold pc and issue nothing, and SHALL move to RUN on the clk where posedge_big_clk=1.
REQ-015 In RUN, each clk SHALL decode one line and then advance pc by one, wrapping from PROG_LEN-1 to 0.
REQ-016 In RUN, opcode==SLP_OP with immediate!=0 SHALL register sleep_val=immediate, pulse sleep_req for 1 clk, advance pc and enter SLP_ACK.
REQ-017 In RUN, opcode==SLP_OP with immediate==0 SHALL behave as an empty line: no sleep_req, no exec_en, pc advances.
REQ-018 In RUN, opcode==0 SHALL be an empty line: pc advances and exec_en stays 0.
REQ-019 In RUN, any other opcode SHALL pulse exec_en for 1 clk, registered and aligned with the pc value of that line, and then advance pc.
REQ-020 In SLP_ACK, the block SHALL wait for sleep_flag=1 and then enter SLP_WAIT.
REQ-021 In SLP_WAIT, the block SHALL hold pc and issue nothing, and SHALL enter RUN on the first clk where sleep_flag=0.
REQ-022 Only pc advance, sleep_req and exec_en SHALL be stalled outside RUN; sleep_val SHALL hold its last value until the next SLP issue.
REQ-023 posedge_big_clk SHALL be ignored in RUN, SLP_ACK and SLP_WAIT.
REQ-024 sleep_req and exec_en SHALL never be high in the same clk.
REQ-025 Two consecutive SLP lines SHALL each produce a full sleep_req/ACK/WAIT handshake, with no merging.
REQ-026 Reaching the last line SHALL never insert an idle cycle: pc wraps to 0 and decode continues in the next clk.
REQ-027 Latency from a decode clk to its exec_en or sleep_req SHALL be 1 clk.
REQ-028 Latency from sleep_flag falling to the next decode SHALL be 1 clk.

Reset
REQ-029 When rst_n=0 at a rising clk edge, the block SHALL set state=IDLE, pc=0, sleep_val=0, sleep_req=0, exec_en=0 and err=0.
REQ-030 A reset in any state, including mid-handshake, SHALL abort the handshake at once, with no residual sleep_req pulse.
REQ-031 After reset, the block SHALL require a fresh posedge_big_clk before leaving IDLE.

Configuration
REQ-032 With macro EXEC_CTRL_ACK_TIMEOUT_EN defined, SLP_ACK SHALL count clks, and if sleep_flag is still 0 after 4 clks the block SHALL set err=1 (sticky until reset) and return to RUN.
REQ-033 Without EXEC_CTRL_ACK_TIMEOUT_EN, SLP_ACK SHALL wait indefinitely, err SHALL be tied to 0, and no timeout counter SHALL be synthesized.

Verification
REQ-034 The bench SHALL check: reset, no posedge_big_clk for 10 clks -> pc=0 and sleep_req, exec_en, err all 0 throughout.
REQ-035 The bench SHALL check: program of 9 non-zero non-SLP lines with one posedge_big_clk pulse -> exec_en high 9 consecutive clks, pc 0..8 then 0.
REQ-036 The bench SHALL check: line 2 = SLP imm 5, with a sleep model that raises sleep_flag 1 clk after sleep_req and drops it after 3 big-clk pulses -> sleep_val=5, one sleep_req pulse, pc frozen at 3 until 1 clk after sleep_flag falls.
REQ-037 The bench SHALL check: line 0 = SLP imm 0 and line 1 = opcode 0 -> no sleep_req, no exec_en, pc reaches 2 in 2 clks.
REQ-038 The bench SHALL check: rst_n=0 asserted in SLP_WAIT -> next clk pc=0 and state IDLE, and sleep_req is not re-issued after reset release.
REQ-039 The bench SHALL check, with EXEC_CTRL_ACK_TIMEOUT_EN defined: SLP issued with sleep_flag held 0 -> err=1 exactly 4 clks after SLP_ACK entry, RUN resumes, err stays 1 until reset.
